// File: rtl/denise_clut_writer.sv
// Denise CLUT write sequencer: merges chipset bus writes, a queued host palette port and
// an optional full-table clear onto one registered CLUT write port. Clear built with CLUT_CLEAR_EN.
module denise_clut_writer #(
  parameter int         HOST_DEPTH = 4,
  parameter logic [8:0] COLORBASE  = 9'h180
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk7_en,
  input  logic [8:1]  i_reg_address_in,
  input  logic [11:0] i_data_in,
  input  logic [2:0]  i_bank,
  input  logic        i_loct,
  input  logic        i_host_valid,
  output logic        o_host_ready,
  input  logic [7:0]  i_host_idx,
  input  logic [23:0] i_host_rgb,
  input  logic        i_clr_req,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_adr,
  output logic [31:0] o_wr_dat,
  output logic [3:0]  o_wr_bs,
  output logic        o_busy,
  output logic        o_clr_done
);

  localparam int AW = (HOST_DEPTH > 1) ? $clog2(HOST_DEPTH) : 1;

  // Host FIFO: entries stored raw as {idx, rgb}; nibble packing happens at issue time.
  logic [31:0] r_fifo_mem [HOST_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_head;
  logic [23:0] w_head_rgb;
  logic        w_bus_hit;
  logic        w_busy_now;

  logic        w_sel_en;
  logic [7:0]  w_sel_adr;
  logic [31:0] w_sel_dat;
  logic [3:0]  w_sel_bs;

  logic        r_wr_en;
  logic [7:0]  r_wr_adr;
  logic [31:0] r_wr_dat;
  logic [3:0]  r_wr_bs;
  logic        r_busy;

  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_host_ready = !w_full && !i_reset;
  assign w_push       = i_host_valid && o_host_ready;
  assign w_head       = r_fifo_mem[r_rptr[AW-1:0]];
  assign w_head_rgb   = w_head[23:0];

  assign w_bus_hit = i_clk7_en && (i_reg_address_in[8:6] == COLORBASE[8:6]);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_mem[r_wptr[AW-1:0]] <= {i_host_idx, i_host_rgb};
    end
  end

`ifdef CLUT_CLEAR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_clr_idx;
  logic       r_clr_done;
  logic       w_clr_step;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_clr_step  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop = !w_bus_hit && !w_empty;
        if (i_clr_req) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // Bus writes steal the slot; the clear index only advances on its own cycles.
        if (!w_bus_hit) begin
          w_clr_step = 1'b1;
          if (r_clr_idx == 8'hFF) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_clr_idx  <= 8'd0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_done <= (r_state == S_DONE);
      if (w_clr_step) begin
        r_clr_idx <= r_clr_idx + 8'd1;
      end
    end
  end

  assign w_busy_now = !w_empty || (r_state != S_IDLE);
  assign o_clr_done = r_clr_done;
`else
  logic w_unused_clr;

  always_comb begin
    w_pop = !w_bus_hit && !w_empty;
  end

  assign w_unused_clr = i_clr_req;
  assign w_busy_now   = !w_empty;
  assign o_clr_done   = 1'b0;
`endif

  // Source select: bus hit > clear step > FIFO head.
  always_comb begin
    w_sel_en  = 1'b0;
    w_sel_adr = 8'd0;
    w_sel_dat = 32'd0;
    w_sel_bs  = 4'd0;
    if (w_bus_hit) begin
      w_sel_en  = 1'b1;
      w_sel_adr = {i_bank, i_reg_address_in[5:1]};
      w_sel_dat = {4'b0, i_data_in, 4'b0, i_data_in};
      w_sel_bs  = i_loct ? 4'b0011 : 4'b1111;
    end
`ifdef CLUT_CLEAR_EN
    else if (w_clr_step) begin
      w_sel_en  = 1'b1;
      w_sel_adr = r_clr_idx;
      w_sel_dat = 32'd0;
      w_sel_bs  = 4'b1111;
    end
`endif
    else if (w_pop) begin
      w_sel_en  = 1'b1;
      w_sel_adr = w_head[31:24];
      w_sel_dat = {4'b0, w_head_rgb[23:20], w_head_rgb[15:12], w_head_rgb[7:4],
                   4'b0, w_head_rgb[19:16], w_head_rgb[11:8],  w_head_rgb[3:0]};
      w_sel_bs  = 4'b1111;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_wr_en  <= 1'b0;
      r_wr_adr <= 8'd0;
      r_wr_dat <= 32'd0;
      r_wr_bs  <= 4'd0;
      r_busy   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_wr_en  <= w_sel_en;
      r_wr_adr <= w_sel_adr;
      r_wr_dat <= w_sel_dat;
      r_wr_bs  <= w_sel_bs;
      r_busy   <= w_busy_now;
    end
  end

  assign o_wr_en  = r_wr_en;
  assign o_wr_adr = r_wr_adr;
  assign o_wr_dat = r_wr_dat;
  assign o_wr_bs  = r_wr_bs;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_denise_clut_writer.sv
// Self-checking bench for denise_clut_writer: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_denise_clut_writer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk7_en;
  logic [8:1]  reg_address_in;
  logic [11:0] data_in;
  logic [2:0]  bank;
  logic        loct;
  logic        host_valid;
  logic        host_ready;
  logic [7:0]  host_idx;
  logic [23:0] host_rgb;
  logic        clr_req;
  logic        wr_en;
  logic [7:0]  wr_adr;
  logic [31:0] wr_dat;
  logic [3:0]  wr_bs;
  logic        busy;
  logic        clr_done;

  always #5 clk = ~clk;

  denise_clut_writer #(.HOST_DEPTH(DEPTH), .COLORBASE(9'h180)) dut (
    .i_clk(clk), .i_reset(rst), .i_clk7_en(clk7_en), .i_reg_address_in(reg_address_in),
    .i_data_in(data_in), .i_bank(bank), .i_loct(loct), .i_host_valid(host_valid),
    .o_host_ready(host_ready), .i_host_idx(host_idx), .i_host_rgb(host_rgb),
    .i_clr_req(clr_req), .o_wr_en(wr_en), .o_wr_adr(wr_adr), .o_wr_dat(wr_dat),
    .o_wr_bs(wr_bs), .o_busy(busy), .o_clr_done(clr_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic quiet();
    clk7_en = 0; reg_address_in = '0; data_in = '0; bank = '0; loct = 0;
    host_valid = 0; host_idx = '0; host_rgb = '0; clr_req = 0;
  endtask

  task automatic bus_drive(input logic [7:0] a, input logic [11:0] d, input logic [2:0] b,
                           input logic l);
    clk7_en = 1; reg_address_in = a; data_in = d; bank = b; loct = l;
  endtask

  // Reference model: host queue, clear position (-1 = not clearing), DONE flag.
  typedef struct packed { logic [7:0] idx; logic [23:0] rgb; } hent_t;
  hent_t       mq[$];
  int          m_clr = -1;
  bit          m_done = 0;
  logic        e_en, e_busy, e_done, e_rdy;
  logic [7:0]  e_adr;
  logic [31:0] e_dat;
  logic [3:0]  e_bs;

  function automatic logic [31:0] rgb_to_clut(input logic [23:0] rgb);
    int r, g, b, hi, lo;
    r = int'(rgb[23:16]); g = int'(rgb[15:8]); b = int'(rgb[7:0]);
    hi = (r / 16) * 256 + (g / 16) * 16 + (b / 16);
    lo = (r % 16) * 256 + (g % 16) * 16 + (b % 16);
    return 32'(hi * 65536 + lo);
  endfunction

  task automatic model_step();
    bit    hit, idle, rdy;
    hent_t h;
    hit    = clk7_en && (reg_address_in[8:6] == 3'b110);
    idle   = (m_clr < 0) && !m_done;
    rdy    = mq.size() < DEPTH;
    e_busy = (mq.size() != 0) || !idle;
    e_done = m_done;
    m_done = 0;
    e_en = 0; e_adr = '0; e_dat = '0; e_bs = '0;
    if (hit) begin
      e_en = 1; e_adr = {bank, reg_address_in[5:1]};
      e_dat = {4'h0, data_in, 4'h0, data_in}; e_bs = loct ? 4'h3 : 4'hF;
    end else if (m_clr >= 0) begin
      e_en = 1; e_adr = 8'(m_clr); e_bs = 4'hF;
      if (m_clr == 255) begin m_clr = -1; m_done = 1; end
      else m_clr++;
    end else if (idle && mq.size() != 0) begin
      h = mq.pop_front();
      e_en = 1; e_adr = h.idx; e_dat = rgb_to_clut(h.rgb); e_bs = 4'hF;
    end
`ifdef CLUT_CLEAR_EN
    if (idle && clr_req) m_clr = 0;
`endif
    if (host_valid && rdy) mq.push_back(hent_t'{host_idx, host_rgb});
    e_rdy = mq.size() < DEPTH;
  endtask

  typedef struct {
    logic c7; logic [7:0] a; logic [11:0] d; logic [2:0] b; logic l;
    logic x_en; logic [7:0] x_adr; logic [31:0] x_dat; logic [3:0] x_bs;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 8'hC3, 12'hABC, 3'd2, 1'b0, 1'b1, 8'h43, 32'h0ABC0ABC, 4'hF};
    vecs[1] = '{1'b1, 8'hC3, 12'hABC, 3'd2, 1'b1, 1'b1, 8'h43, 32'h0ABC0ABC, 4'h3};
    vecs[2] = '{1'b1, 8'hC0, 12'h123, 3'd0, 1'b0, 1'b1, 8'h00, 32'h01230123, 4'hF};
    vecs[3] = '{1'b1, 8'hDF, 12'hFFF, 3'd7, 1'b1, 1'b1, 8'hFF, 32'h0FFF0FFF, 4'h3};
    vecs[4] = '{1'b1, 8'hE0, 12'h777, 3'd1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0};
    vecs[5] = '{1'b1, 8'h80, 12'h777, 3'd1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0};
    vecs[6] = '{1'b0, 8'hC3, 12'h777, 3'd1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0};
    vecs[7] = '{1'b1, 8'hD5, 12'h5A5, 3'd5, 1'b0, 1'b1, 8'hB5, 32'h05A505A5, 4'hF};

    quiet();
    repeat (2) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_host_ready", host_ready, 0);
    rst = 0;
    #1 chk("post_rst_ready", host_ready, 1);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_gap_en", i), wr_en, 0);
      clk7_en = vecs[i].c7; reg_address_in = vecs[i].a; data_in = vecs[i].d;
      bank = vecs[i].b; loct = vecs[i].l;
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), wr_en, vecs[i].x_en);
      if (vecs[i].x_en) begin
        chk($sformatf("vec%0d_adr", i), wr_adr, vecs[i].x_adr);
        chk($sformatf("vec%0d_dat", i), wr_dat, vecs[i].x_dat);
        chk($sformatf("vec%0d_bs", i), wr_bs, vecs[i].x_bs);
      end
      quiet();
    end

    // Host write latency: issued two cycles after the push.
    @(negedge clk); quiet();
    chk("host_ready_idle", host_ready, 1);
    host_valid = 1; host_idx = 8'h10; host_rgb = 24'h123456;
    @(negedge clk); quiet();
    chk("host_lat1_en", wr_en, 0);
    @(negedge clk);
    chk("host_en", wr_en, 1);
    chk("host_adr", wr_adr, 8'h10);
    chk("host_dat", wr_dat, 32'h01350246);
    chk("host_bs", wr_bs, 4'hF);
    chk("host_busy", busy, 1);
    @(negedge clk);
    chk("host_after_en", wr_en, 0);
    chk("host_after_busy", busy, 0);

    // Collision: bus hit wins, host follows next cycle.
    @(negedge clk); quiet();
    host_valid = 1; host_idx = 8'h20; host_rgb = 24'hFFFFFF;
    @(negedge clk); quiet();
    bus_drive(8'hC3, 12'h111, 3'd1, 1'b0);
    @(negedge clk); quiet();
    chk("coll_bus_en", wr_en, 1);
    chk("coll_bus_adr", wr_adr, 8'h23);
    chk("coll_bus_dat", wr_dat, 32'h01110111);
    @(negedge clk);
    chk("coll_host_en", wr_en, 1);
    chk("coll_host_adr", wr_adr, 8'h20);
    chk("coll_host_dat", wr_dat, 32'h0FFF0FFF);
    @(negedge clk);
    chk("coll_end_en", wr_en, 0);

    // FIFO full while bus hits occupy every slot.
    begin : fifo_full
      int         bus_seen;
      bit         accepted;
      logic [7:0] hq[$];
      bus_seen = 0; accepted = 0;
      for (int i = 0; i < 27; i++) begin
        @(negedge clk);
        if (wr_en) begin
          if (wr_adr == 8'hFF && wr_dat == 32'h05A505A5) bus_seen++;
          else hq.push_back(wr_adr);
        end
        quiet();
        if (i < 4) begin
          chk($sformatf("full_ready_%0d", i), host_ready, 1);
          bus_drive(8'hDF, 12'h5A5, 3'd7, 1'b0);
          host_valid = 1; host_idx = 8'(8'h30 + i); host_rgb = 24'h102030;
        end else if (i < 7) begin
          chk($sformatf("full_ready_low_%0d", i), host_ready, 0);
          bus_drive(8'hDF, 12'h5A5, 3'd7, 1'b0);
          host_valid = 1; host_idx = 8'h34; host_rgb = 24'h102030;
        end else if (!accepted && host_ready) begin
          host_valid = 1; host_idx = 8'h34; host_rgb = 24'h102030; accepted = 1;
        end
      end
      chk("full_bus_count", bus_seen, 7);
      chk("full_fifth_accepted", accepted, 1);
      chk("full_host_count", hq.size(), 5);
      for (int k = 0; k < hq.size() && k < 5; k++)
        chk($sformatf("full_order_%0d", k), hq[k], 8'(8'h30 + k));
      chk("full_busy_end", busy, 0);
    end

`ifdef CLUT_CLEAR_EN
    for (int pass = 0; pass < 2; pass++) begin : clr_t
      int cyc, nclr, bad, nbus;
      bit seen;
      cyc = 0; nclr = 0; bad = 0; nbus = 0; seen = 0;
      @(negedge clk); quiet(); clr_req = 1;
      for (int k = 0; k < 700 && !seen; k++) begin
        @(negedge clk); quiet(); cyc++;
        if (wr_en) begin
          if (wr_dat == 32'h0) begin
            if (wr_adr != 8'(nclr) || wr_bs != 4'hF) bad++;
            nclr++;
          end else nbus++;
        end
        if (clr_done) seen = 1;
        if (pass == 1 && k < 90 && (k % 3) == 0) bus_drive(8'hDF, 12'h5A5, 3'd7, 1'b0);
      end
      chk($sformatf("clr%0d_done_seen", pass), seen, 1);
      chk($sformatf("clr%0d_cycles", pass), cyc, 258 + pass * 30);
      chk($sformatf("clr%0d_writes", pass), nclr, 256);
      chk($sformatf("clr%0d_seq_bad", pass), bad, 0);
      chk($sformatf("clr%0d_bus", pass), nbus, pass * 30);
      chk($sformatf("clr%0d_busy_at_done", pass), busy, 1);
      @(negedge clk);
      chk($sformatf("clr%0d_done_pulse", pass), clr_done, 0);
      chk($sformatf("clr%0d_busy_end", pass), busy, 0);
    end
`endif

    // Reset in the middle of activity with two queued host entries.
    begin : rst_t
      int  nwr, nbusy;
      bit  found;
`ifdef CLUT_CLEAR_EN
      @(negedge clk); quiet();
      clr_req = 1; host_valid = 1; host_idx = 8'h40; host_rgb = 24'h111111;
      @(negedge clk); quiet();
      host_valid = 1; host_idx = 8'h41; host_rgb = 24'h222222;
      @(negedge clk); quiet();
      found = 0;
      for (int k = 0; k < 400 && !found; k++) begin
        @(negedge clk);
        if (wr_en && wr_adr == 8'd99 && wr_dat == 32'h0) found = 1;
      end
      chk("rst_reach_idx100", found, 1);
`else
      @(negedge clk); quiet();
      bus_drive(8'hDF, 12'h5A5, 3'd7, 1'b0);
      host_valid = 1; host_idx = 8'h40; host_rgb = 24'h111111;
      @(negedge clk); quiet();
      bus_drive(8'hDF, 12'h5A5, 3'd7, 1'b0);
      host_valid = 1; host_idx = 8'h41; host_rgb = 24'h222222;
      @(negedge clk); quiet();
      bus_drive(8'hDF, 12'h5A5, 3'd7, 1'b0);
      @(negedge clk); quiet();
      chk("rst_pre_wr_en", wr_en, 1);
`endif
      chk("rst_pre_busy", busy, 1);
      #2 rst = 1;
      #1;
      chk("rst_mid_wr_en", wr_en, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready", host_ready, 0);
      chk("rst_mid_clr_done", clr_done, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      #1 chk("rst_release_ready", host_ready, 1);
      nwr = 0; nbusy = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (wr_en) nwr++;
        if (busy) nbusy++;
      end
      chk("rst_no_writes_after", nwr, 0);
      chk("rst_no_busy_after", nbusy, 0);
    end

    // Randomized traffic against the reference model.
    mq.delete(); m_clr = -1; m_done = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("rnd_wr_en", wr_en, e_en);
        if (e_en) begin
          chk("rnd_wr_adr", wr_adr, e_adr);
          chk("rnd_wr_dat", wr_dat, e_dat);
          chk("rnd_wr_bs", wr_bs, e_bs);
        end
        chk("rnd_busy", busy, e_busy);
        chk("rnd_clr_done", clr_done, e_done);
        chk("rnd_host_ready", host_ready, e_rdy);
      end
      quiet();
      clk7_en = ($urandom_range(0, 3) == 0);
      reg_address_in = ($urandom_range(0, 1) == 1) ? {3'b110, 5'($urandom)} : 8'($urandom);
      data_in = 12'($urandom); bank = 3'($urandom); loct = 1'($urandom);
      host_valid = 1'($urandom); host_idx = 8'($urandom); host_rgb = 24'($urandom);
`ifdef CLUT_CLEAR_EN
      clr_req = ($urandom_range(0, 399) == 0);
`endif
      model_step();
    end
    @(negedge clk); quiet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/denise_clut_writer.md
Name: denise_clut_writer

Overview:
- Write-port sequencer and arbiter for the Denise 256-entry colour lookup table.
- Merges three write sources into one registered CLUT write port:
  - chipset register-bus writes to COLOR00-31, honouring bank and LOCT;
  - host palette writes with 24-bit RGB, queued in a small FIFO;
  - an optional full-table clear sequence.
- Sits between the register bus / host control interface and the colour-table RAM.

Parameters:
HOST_DEPTH, 4, host write FIFO depth in entries (power of two, 2..16)
COLORBASE, 9'h180, colour register base address; bits [8:6] are decoded

Ports:
clk  in  1  28MHz clock
reset  in  1  asynchronous reset, active-high
clk7_en  in  1  7MHz clock enable; qualifies bus writes
reg_address_in  in  8  register address [8:1]
data_in  in  12  register bus data
bank  in  3  colour bank select
loct  in  1  1 = bus write targets the low-nibble half
host_valid  in  1  host write request
host_ready  out  1  host write accepted when high together with host_valid
host_idx  in  8  host CLUT index
host_rgb  in  24  host colour {R8,G8,B8}
clr_req  in  1  clear-table request pulse
wr_en  out  1  CLUT write strobe
wr_adr  out  8  CLUT write address
wr_dat  out  32  CLUT write data {4'b0,hi12,4'b0,lo12}
wr_bs  out  4  CLUT byte enables
busy  out  1  FIFO non-empty or clear in progress
clr_done  out  1  one-cycle pulse when a clear finishes

Behaviour:
- Reset: wr_en/wr_adr/wr_dat/wr_bs/busy/clr_done = 0; host_ready = 0 while reset is asserted; FIFO empty; FSM in IDLE; clear index = 0.
- Bus hit:
  - Condition: clk7_en && reg_address_in[8:6]==COLORBASE[8:6].
  - Write issued: adr = {bank, reg_address_in[5:1]}, dat = {4'b0,data_in,4'b0,data_in}, bs = loct ? 4'b0011 : 4'b1111.
- Host entry conversion:
  - hi = {R[7:4],G[7:4],B[7:4]}, lo = {R[3:0],G[3:0],B[3:0]}.
  - Issued with adr = host_idx, dat = {4'b0,hi,4'b0,lo}, bs = 4'b1111.
- Output timing: all wr_* outputs are registered. A source selected in cycle N appears on wr_* in cycle N+1. wr_en is high for exactly one cycle per write.
- Priority per cycle: bus hit > clear step > FIFO head. Bus writes are never delayed or dropped.
- FSM states:
  - IDLE → CLEAR on clr_req. In IDLE, the FIFO head is popped and issued in any cycle without a bus hit.
  - CLEAR: in each cycle without a bus hit, write index i with dat = 0 and bs = 4'b1111, then i++. After writing i = 255: i wraps to 0, go to DONE.
  - DONE: clr_done = 1 for one cycle, then IDLE.
- Clear interaction rules:
  - The FIFO does not drain during CLEAR or DONE.
  - clr_req is ignored outside IDLE.
  - A bus write during CLEAR is performed as normal. The clear does not rewind, so a bus write to an index not yet cleared is later overwritten with 0. This is intended.
- FIFO:
  - host_ready = !full && !reset. Push on host_valid && host_ready.
  - Simultaneous push and pop is allowed when full; the write pointer must not overrun.
  - When empty, a push becomes visible to the pop logic the next cycle, so there is no same-cycle bypass.
  - Entries are issued in order.
- busy: registered; busy = (FIFO non-empty) || state != IDLE.
- Reset mid-clear or with a non-empty FIFO: abort immediately and flush the FIFO; no further writes.

Optional Feature:
CLUT_CLEAR_EN
- Defined: CLEAR/DONE states and the 8-bit clear index are present, behaving as above.
- Undefined:
  - clr_req is ignored and clr_done is tied to 0.
  - The FSM reduces to IDLE, and busy = FIFO non-empty.
  - Bus and host behaviour are unchanged.

Test Plan:
- Bus write: reg_address_in=8'hC3 (addr 0x186), bank=3'b010, loct=0, data_in=12'hABC, clk7_en=1 → next cycle wr_en=1, wr_adr=8'h43, wr_dat=32'h0ABC0ABC, wr_bs=4'hF; with loct=1 → wr_bs=4'h3.
- Host write: host_idx=8'h10, host_rgb=24'h12_34_56, FIFO empty, no bus traffic → wr_adr=8'h10, wr_dat=32'h01350246 two cycles after the push.
- Collision: bus hit in the same cycle the FIFO head is ready → bus write issued first, host write in the following cycle; no data lost.
- FIFO full: push 5 entries back-to-back while clk7_en bus hits occupy every slot → host_ready=0 after 4 entries; all 4 entries later issued in order; the 5th is accepted once ready rises.
- Clear (CLUT_CLEAR_EN):
  - Stimulus: clr_req with no bus traffic.
  - Response: 256 consecutive writes of 0 to adr 0..255, then clr_done one cycle later, then busy=0.
  - Repeat with clk7_en bus hits: total cycles = 256 + number of bus hits.
- Reset: assert reset at clear index 100 with 2 FIFO entries → wr_en=0, busy=0, host_ready=0 immediately; after release, no further writes occur and host_ready=1.
